// File: rtl/btn_event.sv
// Button gesture decoder: turns a debounced button level into single-cycle
// press/release/click/double/long/repeat pulses using a 1 ms prescaled timer.
module btn_event #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DOUBLE_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn,
    output logic       o_press,
    output logic       o_release,
    output logic       o_click,
    output logic       o_double,
    output logic       o_long,
    output logic       o_repeat,
    output logic [2:0] o_state
);

    localparam int unsigned MAX_LD = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
    localparam int unsigned MAX_MS = (MAX_LD > REPEAT_MS) ? MAX_LD : REPEAT_MS;
    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned MS_W   = $clog2(MAX_MS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } state_e;

    state_e            state_q;
    logic              btn_q;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic              press_q, release_q, click_q, double_q, long_q, repeat_q;

    logic rise_c, fall_c, tick_c, timed_c;
    logic long_exp_c, dbl_exp_c, rep_exp_c;

    assign rise_c  = i_btn & ~btn_q;
    assign fall_c  = ~i_btn & btn_q;
    assign tick_c  = (pre_q == PRE_W'(TICK_DIV - 1));
    assign timed_c = (state_q == PRESS1) || (state_q == LONG) || (state_q == WAIT2);

    assign long_exp_c = tick_c && (ms_q == MS_W'(LONG_MS - 1));
    assign dbl_exp_c  = tick_c && (ms_q == MS_W'(DOUBLE_MS - 1));
    assign rep_exp_c  = tick_c && (ms_q == MS_W'(REPEAT_MS - 1));

    // Timer only runs in states that own a deadline, so ms can never wrap.
    always_comb begin
        pre_d = '0;
        ms_d  = '0;
        if (timed_c) begin
            if (tick_c) begin
                pre_d = '0;
                ms_d  = ms_q + MS_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
                ms_d  = ms_q;
            end
        end
    end

    // Edges are checked before expiries so a same-cycle edge always wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            btn_q     <= 1'b0;
            pre_q     <= '0;
            ms_q      <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            btn_q     <= i_btn;
            press_q   <= rise_c;
            release_q <= fall_c;
            click_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            pre_q     <= pre_d;
            ms_q      <= ms_d;

            case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        state_q <= PRESS1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end
                end
                PRESS1: begin
                    if (fall_c) begin
                        state_q <= WAIT2;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end else if (long_exp_c) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end
                end
                LONG: begin
                    if (fall_c) begin
                        state_q <= IDLE;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end else if (rep_exp_c) begin
                        repeat_q <= 1'b1;
                        pre_q    <= '0;
                        ms_q     <= '0;
                    end
                end
                WAIT2: begin
                    if (rise_c) begin
                        state_q  <= PRESS2;
                        double_q <= 1'b1;
                        pre_q    <= '0;
                        ms_q     <= '0;
                    end else if (dbl_exp_c) begin
                        state_q <= IDLE;
                        click_q <= 1'b1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end
                end
                PRESS2: begin
                    if (fall_c) begin
                        state_q <= IDLE;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pre_q   <= '0;
                    ms_q    <= '0;
                end
            endcase
        end
    end

    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_click   = click_q;
    assign o_double  = double_q;
    assign o_long    = long_q;
    assign o_repeat  = repeat_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event: a per-cycle vector table for reset and short
// gestures, then hand-written multi-cycle sequences for timed events.
module tb_btn_event;

    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] PR = 6'b100000;
    localparam logic [5:0] RL = 6'b010000;
    localparam logic [5:0] CK = 6'b001000;
    localparam logic [5:0] DB = 6'b000100;
    localparam logic [5:0] LG = 6'b000010;
    localparam logic [5:0] RP = 6'b000001;

    logic       clk;
    logic       rst_n;
    logic       i_btn;
    logic       o_press, o_release, o_click, o_double, o_long, o_repeat;
    logic [2:0] o_state;

    int n_vec;
    int n_err;

    btn_event #(
        .TICK_DIV (10),
        .LONG_MS  (20),
        .DOUBLE_MS(5),
        .REPEAT_MS(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (i_btn),
        .o_press  (o_press),
        .o_release(o_release),
        .o_click  (o_click),
        .o_double (o_double),
        .o_long   (o_long),
        .o_repeat (o_repeat),
        .o_state  (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       btn;
        logic [5:0] pulses;
        logic [2:0] state;
    } vec_t;

    // One clock: drive inputs, take the posedge, check outputs 1 time unit later.
    task automatic step(input logic r, input logic b, input logic [5:0] ep,
                        input logic [2:0] es, input string tag, input int idx);
        logic [5:0] ap;
        rst_n = r;
        i_btn = b;
        @(posedge clk);
        #1;
        ap = {o_press, o_release, o_click, o_double, o_long, o_repeat};
        n_vec++;
        if (ap !== ep || o_state !== es) begin
            n_err++;
            $display("FAIL %s #%0d: got pulses=%b state=%0d, want pulses=%b state=%0d",
                     tag, idx, ap, o_state, ep, es);
        end
    endtask

    vec_t       vecs [18];
    logic       b;
    logic [5:0] ep;
    logic [2:0] es;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        i_btn = 1'b0;

        vecs[0]  = '{1'b0, 1'b1, NO,      3'd0};
        vecs[1]  = '{1'b0, 1'b0, NO,      3'd0};
        vecs[2]  = '{1'b0, 1'b1, NO,      3'd0};
        vecs[3]  = '{1'b1, 1'b0, NO,      3'd0};
        vecs[4]  = '{1'b1, 1'b0, NO,      3'd0};
        vecs[5]  = '{1'b1, 1'b1, PR,      3'd1};
        vecs[6]  = '{1'b1, 1'b1, NO,      3'd1};
        vecs[7]  = '{1'b1, 1'b0, RL,      3'd3};
        vecs[8]  = '{1'b1, 1'b1, PR | DB, 3'd4};
        vecs[9]  = '{1'b1, 1'b1, NO,      3'd4};
        vecs[10] = '{1'b1, 1'b0, RL,      3'd0};
        vecs[11] = '{1'b1, 1'b0, NO,      3'd0};
        vecs[12] = '{1'b1, 1'b1, PR,      3'd1};
        vecs[13] = '{1'b0, 1'b1, NO,      3'd0};
        vecs[14] = '{1'b1, 1'b1, PR,      3'd1};
        vecs[15] = '{1'b1, 1'b0, RL,      3'd3};
        vecs[16] = '{1'b0, 1'b0, NO,      3'd0};
        vecs[17] = '{1'b1, 1'b0, NO,      3'd0};

        for (int i = 0; i < 18; i++)
            step(vecs[i].rst_n, vecs[i].btn, vecs[i].pulses, vecs[i].state, "table", i);

        // Single click: press 30 cycles, click 50 cycles after release.
        for (int k = 0; k < 100; k++) begin
            b  = (k < 30);
            ep = (k == 0) ? PR : (k == 30) ? RL : (k == 80) ? CK : NO;
            es = (k < 30) ? 3'd1 : (k < 80) ? 3'd3 : 3'd0;
            step(1'b1, b, ep, es, "click", k);
        end

        // Double click inside the window.
        for (int k = 0; k < 120; k++) begin
            b  = (k < 30) || (k >= 50 && k < 80);
            ep = (k == 0) ? PR : (k == 30) ? RL : (k == 50) ? (PR | DB) : (k == 80) ? RL : NO;
            es = (k < 30) ? 3'd1 : (k < 50) ? 3'd3 : (k < 80) ? 3'd4 : 3'd0;
            step(1'b1, b, ep, es, "double", k);
        end

        // Long hold with two repeats before release.
        for (int k = 0; k < 340; k++) begin
            b  = (k < 300);
            ep = (k == 0) ? PR : (k == 200) ? LG : (k == 240 || k == 280) ? RP :
                 (k == 300) ? RL : NO;
            es = (k < 200) ? 3'd1 : (k < 300) ? 3'd2 : 3'd0;
            step(1'b1, b, ep, es, "long", k);
        end

        // Release on the long-expiry edge: no o_long, falls into WAIT2.
        for (int k = 0; k < 260; k++) begin
            b  = (k < 200);
            ep = (k == 0) ? PR : (k == 200) ? RL : (k == 250) ? CK : NO;
            es = (k < 200) ? 3'd1 : (k < 250) ? 3'd3 : 3'd0;
            step(1'b1, b, ep, es, "long_edge", k);
        end

        // Second press on the double-expiry edge, then an indefinite hold in PRESS2.
        for (int k = 0; k < 360; k++) begin
            b  = (k < 30) || (k >= 80 && k < 330);
            ep = (k == 0) ? PR : (k == 30) ? RL : (k == 80) ? (PR | DB) : (k == 330) ? RL : NO;
            es = (k < 30) ? 3'd1 : (k < 80) ? 3'd3 : (k < 330) ? 3'd4 : 3'd0;
            step(1'b1, b, ep, es, "dbl_edge", k);
        end

        // Reset during WAIT2 discards the click; then button held across reset release.
        for (int k = 0; k < 160; k++) begin
            logic r;
            r  = !((k >= 20 && k < 22) || (k >= 100 && k < 102));
            b  = (k < 10) || (k >= 100 && k < 103);
            ep = (k == 0) ? PR : (k == 10) ? RL : (k == 102) ? PR : (k == 103) ? RL :
                 (k == 153) ? CK : NO;
            es = (k < 10) ? 3'd1 : (k < 20) ? 3'd3 : (k < 102) ? 3'd0 :
                 (k == 102) ? 3'd1 : (k < 153) ? 3'd3 : 3'd0;
            step(r, b, ep, es, "mid_reset", k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
